// File: rtl/ext_ipa_pkg.sv
// Shared types and default widths for the external-unit IPA blocks.
package ext_ipa_pkg;

  localparam int unsigned EXT_DATA_WIDTH = 32;
  localparam int unsigned EXT_ADDR_WIDTH = 32;
  localparam int unsigned EXT_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ext_load_state_e;

endpackage

// File: rtl/ext_buffer_ipa.sv
// Small valid/ready FIFO; the head entry is presented combinationally on data_o.
module ext_buffer_ipa #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i
);

  localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]     fill_q;
  logic                  push, pop;

  assign ready_o = (fill_q != FILL_MAX);
  assign valid_o = (fill_q != '0);
  // Empty buffer shows zero rather than stale or uninitialised storage.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: storage has no reset; only pointers and fill level are reset, which is enough to mark it empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/ext_load_unit_ipa.sv
// Strided load engine: issues single-word reads and streams responses in order,
// with a credit counter bounding in-flight reads plus queued words.
module ext_load_unit_ipa
  import ext_ipa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = EXT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = EXT_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH       = EXT_CNT_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i
);

  localparam int unsigned CRED_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);

  ext_load_state_e       state_q;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [CNT_WIDTH-1:0]  cnt_q, req_cnt_q, out_cnt_q;
  logic [CRED_W-1:0]     credits_q;
  logic                  busy_q, done_q;
  logic                  grant, hs, rsp_push, rsp_ready;

  // Request depends only on registered state, so it holds until granted.
  assign mem_req_o  = (state_q == RUN) && (req_cnt_q != cnt_q) && (credits_q != '0);
  assign mem_addr_o = addr_q;
  assign grant      = mem_req_o && mem_gnt_i;
  assign hs         = valid_o && ready_i;
  assign rsp_push   = mem_rvalid_i && (state_q != IDLE);
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      cnt_q     <= '0;
      req_cnt_q <= '0;
      out_cnt_q <= '0;
      credits_q <= CRED_MAX;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (state_q != IDLE) begin
        if (grant) begin
          addr_q    <= addr_q + stride_q;
          req_cnt_q <= req_cnt_q + 1'b1;
        end
        if (hs) out_cnt_q <= out_cnt_q + 1'b1;
        // A grant and a handshake in the same cycle cancel out.
        case ({grant, hs})
          2'b10:   credits_q <= credits_q - 1'b1;
          2'b01:   credits_q <= credits_q + 1'b1;
          default: credits_q <= credits_q;
        endcase
      end

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q    <= base_addr_i;
            stride_q  <= stride_i;
            cnt_q     <= count_i;
            req_cnt_q <= '0;
            out_cnt_q <= '0;
            credits_q <= CRED_MAX;
            busy_q    <= 1'b1;
            done_q    <= (count_i == '0);
            state_q   <= (count_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (grant && (req_cnt_q + 1'b1 == cnt_q)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (hs && (out_cnt_q + 1'b1 == cnt_q)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  ext_buffer_ipa #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BUFFER_DEPTH (MAX_OUTSTANDING)
  ) u_rsp_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (rsp_push),
    .data_i  (mem_rdata_i),
    .ready_o (rsp_ready),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  // Credits guarantee a response always finds room in the queue.
  rsp_no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_push |-> rsp_ready);

endmodule

// File: tb/tb_ext_load_unit_ipa.sv
// Directed bench for ext_load_unit_ipa with a cycle-stepped memory model.
module tb_ext_load_unit_ipa;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] base_addr_i, stride_i;
  logic [15:0] count_i;
  logic        busy_o, done_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ready_i;

  ext_load_unit_ipa dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .stride_i     (stride_i),
    .count_i      (count_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] gnt_addr_q[$];
  int          gnt_cyc_q[$];
  logic [31:0] out_data_q[$];
  int          out_cyc_q[$];
  int          done_cyc_q[$];

  int          cyc;
  int          start_cyc;
  int          n_vec;
  int          n_err;
  bit          rand_mode;
  bit          prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: called at a negedge, drives the memory side, logs DUT activity.
  task automatic tick();
    logic gnt;
    if (rand_mode) ready_i = 1'($urandom_range(0, 1));
    if (rand_mode && prev_stall) begin
      check("req_hold", mem_req_o, 1'b1);
      check("addr_hold", mem_addr_o, prev_addr);
    end
    gnt          = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_gnt_i    = gnt;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_model(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    if (mem_req_o && gnt) begin
      gnt_addr_q.push_back(mem_addr_o);
      gnt_cyc_q.push_back(cyc);
      pend_q.push_back('{addr: mem_addr_o, due: cyc + 1 + (rand_mode ? int'($urandom_range(0, 2)) : 0)});
    end
    prev_stall = mem_req_o && !gnt;
    prev_addr  = mem_addr_o;
    if (valid_o && ready_i) begin
      out_data_q.push_back(data_o);
      out_cyc_q.push_back(cyc);
    end
    if (done_o) done_cyc_q.push_back(cyc);
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic kick(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] count);
    gnt_addr_q.delete();
    gnt_cyc_q.delete();
    out_data_q.delete();
    out_cyc_q.delete();
    done_cyc_q.delete();
    start_cyc   = cyc;
    start_i     = 1'b1;
    base_addr_i = base;
    stride_i    = stride;
    count_i     = count;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && done_cyc_q.size() == 0; n++) tick();
    check("done_seen", done_cyc_q.size() != 0, 1'b1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input logic [31:0] stride, input int count);
    check({tag, "_ngnt"}, gnt_addr_q.size(), count);
    check({tag, "_nout"}, out_data_q.size(), count);
    for (int i = 0; i < count && i < gnt_addr_q.size() && i < out_data_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), gnt_addr_q[i], base + stride * i);
      check($sformatf("%s_data%0d", tag, i), out_data_q[i], mem_model(base + stride * i));
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    cyc          = 0;
    rand_mode    = 1'b0;
    prev_stall   = 1'b0;
    prev_addr    = '0;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    base_addr_i  = '0;
    stride_i     = '0;
    count_i      = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    ready_i      = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Reset state
    check("rst_req",   mem_req_o,  1'b0);
    check("rst_addr",  mem_addr_o, 32'h0);
    check("rst_valid", valid_o,    1'b0);
    check("rst_data",  data_o,     32'h0);
    check("rst_busy",  busy_o,     1'b0);
    check("rst_done",  done_o,     1'b0);

    // Zero-wait memory, full throughput
    kick(32'h1000, 32'd4, 16'd8);
    check("t1_busy_c1", busy_o, 1'b1);
    check("t1_req_c1",  mem_req_o, 1'b1);
    wait_done(100);
    check_stream("t1", 32'h1000, 32'd4, 8);
    for (int i = 0; i < 8 && i < gnt_cyc_q.size() && i < out_cyc_q.size(); i++) begin
      check($sformatf("t1_gcyc%0d", i), gnt_cyc_q[i], start_cyc + 1 + i);
      check($sformatf("t1_ocyc%0d", i), out_cyc_q[i], start_cyc + 3 + i);
    end
    if (out_cyc_q.size() == 8 && done_cyc_q.size() > 0)
      check("t1_done_cyc", done_cyc_q[0], out_cyc_q[7] + 1);
    check("t1_busy_end", busy_o, 1'b0);

    // Negative stride wrapping through zero
    kick(32'h0, 32'hFFFF_FFFC, 16'd3);
    wait_done(100);
    check("t2_ngnt", gnt_addr_q.size(), 3);
    if (gnt_addr_q.size() == 3) begin
      check("t2_addr0", gnt_addr_q[0], 32'h0000_0000);
      check("t2_addr1", gnt_addr_q[1], 32'hFFFF_FFFC);
      check("t2_addr2", gnt_addr_q[2], 32'hFFFF_FFF8);
    end

    // Stream back-pressure: credits cap requests at four
    ready_i = 1'b0;
    kick(32'h5000, 32'd4, 16'd10);
    repeat (19) tick();
    check("t3_ngnt_stalled", gnt_addr_q.size(), 4);
    check("t3_req_low",      mem_req_o, 1'b0);
    check("t3_valid_held",   valid_o, 1'b1);
    check("t3_nout_stalled", out_data_q.size(), 0);
    ready_i = 1'b1;
    wait_done(200);
    check_stream("t3", 32'h5000, 32'd4, 10);

    // Random grant stalls, latency and ready; a start pulse mid-run is ignored
    rand_mode = 1'b1;
    kick(32'h2000_0000, 32'h10, 16'd12);
    repeat (5) tick();
    start_i     = 1'b1;
    base_addr_i = 32'hDEAD_0000;
    count_i     = 16'd1;
    tick();
    start_i     = 1'b0;
    wait_done(600);
    rand_mode  = 1'b0;
    prev_stall = 1'b0;
    ready_i    = 1'b1;
    check_stream("t4", 32'h2000_0000, 32'h10, 12);
    repeat (3) tick();
    check("t4_idle_after", busy_o, 1'b0);
    check("t4_no_extra",   gnt_addr_q.size(), 12);

    // Zero count; start pulsed while in DONE is ignored
    kick(32'h7000, 32'd4, 16'd0);
    check("t5_done_c1", done_o, 1'b1);
    check("t5_busy_c1", busy_o, 1'b1);
    check("t5_req_c1",  mem_req_o, 1'b0);
    start_i = 1'b1;
    count_i = 16'd3;
    tick();
    start_i = 1'b0;
    check("t5_done_c2", done_o, 1'b0);
    check("t5_busy_c2", busy_o, 1'b0);
    tick();
    check("t5_busy_c3", busy_o, 1'b0);
    check("t5_ngnt",    gnt_addr_q.size(), 0);

    // Reset mid-RUN with two words queued, then a clean run
    ready_i = 1'b0;
    kick(32'h3000, 32'd4, 16'd8);
    repeat (3) tick();
    check("t6_queued", valid_o, 1'b1);
    check("t6_head",   data_o, mem_model(32'h3000));
    rst_ni       = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    pend_q.delete();
    #1;
    check("t6_rst_req",   mem_req_o,  1'b0);
    check("t6_rst_addr",  mem_addr_o, 32'h0);
    check("t6_rst_valid", valid_o,    1'b0);
    check("t6_rst_data",  data_o,     32'h0);
    check("t6_rst_busy",  busy_o,     1'b0);
    check("t6_rst_done",  done_o,     1'b0);
    @(negedge clk_i);
    cyc++;
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    cyc++;
    kick(32'h4000, 32'd8, 16'd5);
    wait_done(100);
    check_stream("t6", 32'h4000, 32'd8, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_load_unit_ipa.md
# ext_load_unit_ipa

Address-generating load engine of the external unit: given a base address, byte stride and word count, it issues single-word reads on the external memory port and streams the returned data in order on a valid/ready output. It sits directly upstream of `ext_buffer_ipa`, whose `valid_i/data_i/ready_o` it drives. A credit counter bounds outstanding reads plus queued words, so memory responses, which cannot be back-pressured, are never dropped.

## Interface
- `DATA_WIDTH`, 32, memory and stream word width
- `ADDR_WIDTH`, 32, memory address width
- `CNT_WIDTH`, 16, width of the word count
- `MAX_OUTSTANDING`, 4, credits; this is also the depth of the internal response queue
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `start_i`  in  1  one-cycle start pulse; sampled only in IDLE
- `base_addr_i`  in  ADDR_WIDTH  first byte address, captured on start
- `stride_i`  in  ADDR_WIDTH  byte increment, captured on start; wraps two's-complement, so negative strides work
- `count_i`  in  CNT_WIDTH  number of words, captured on start
- `busy_o`  out  1  high from the cycle after start until the done pulse
- `done_o`  out  1  one-cycle pulse when the last word completes its output handshake
- `mem_req_o`  out  1  read request
- `mem_addr_o`  out  ADDR_WIDTH  read address
- `mem_gnt_i`  in  1  request accepted
- `mem_rvalid_i`  in  1  response valid; in order, at least 1 cycle after its grant
- `mem_rdata_i`  in  DATA_WIDTH  response data
- `valid_o`  out  1  stream valid, to `ext_buffer_ipa.valid_i`
- `data_o`  out  DATA_WIDTH  stream data
- `ready_i`  in  1  stream ready, from `ext_buffer_ipa.ready_o`

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE + `start_i`:
  - capture `addr_q = base_addr_i`, `stride_q` and `cnt_q`.
  - Clear `req_cnt` and `out_cnt`; set `credits = MAX_OUTSTANDING`.
  - Go to RUN, or to DONE if `count_i == 0`.
- RUN:
  - `mem_req_o = (req_cnt != cnt_q) && (credits != 0)`; `mem_addr_o = addr_q`.
  - On `mem_req_o && mem_gnt_i`: `addr_q += stride_q` (mod 2^ADDR_WIDTH), `req_cnt++`, `credits--`.
  - After the grant where `req_cnt` reaches `cnt_q`, go to DRAIN.
- Request stability: once `mem_req_o` rises, it and `mem_addr_o` hold until granted. Credits only decrease on a grant, so the request cannot drop early.
- `mem_rvalid_i`: pushes `mem_rdata_i` into the response queue unconditionally. It is ignored in IDLE.
- Output: `valid_o`/`data_o` come from the queue head. A handshake (`valid_o && ready_i`) does `out_cnt++`, `credits++`.
- Grant and handshake in the same cycle: `credits` unchanged.
- Invariant: in-flight reads + queued words ≤ MAX_OUTSTANDING, so the queue never overflows.
- DRAIN → DONE when the handshake makes `out_cnt == cnt_q`.
- DONE: `done_o = 1` for one cycle, then IDLE. `start_i` is ignored in RUN, DRAIN and DONE.
- Reset mid-operation: all state returns to reset values and the queue empties. The memory side is reset on the same `rst_ni`, so no late responses arrive.
- Reset values: `mem_req_o=0`, `mem_addr_o=0`, `valid_o=0`, `data_o=0`, `busy_o=0`, `done_o=0`; state IDLE.

## Timing
- Start pulse at cycle 0 → `busy_o=1` and first `mem_req_o=1` at cycle 1. A grant may come in the same cycle as the request.
- Response at cycle r → `valid_o` at r+1, because the queue registers it.
- Zero-wait memory with rvalid at grant+1 and `ready_i` tied high: one word per cycle needs ≥3 credits, so the default of 4 sustains full throughput.
- Last output handshake at cycle h → `done_o=1` at h+1, `busy_o=0` at h+2.
- `count_i=0`: `done_o` at cycle 1; no memory request is ever raised.

## Structure
- Shared package `ext_ipa_pkg` holds:
  - `ext_load_state_e` (IDLE, RUN, DRAIN, DONE);
  - default width constants for data, address and count.
- Response queue: one instance of the existing `ext_buffer_ipa` with `BUFFER_DEPTH = MAX_OUTSTANDING` and `DATA_WIDTH = DATA_WIDTH`.
- The FSM, address, counters and credit logic are local to this module.

## Test plan
- Base 0x1000, stride 4, count 8, zero-wait memory (gnt same cycle, rvalid +1), `ready_i=1`:
  - addresses 0x1000..0x101C on consecutive cycles;
  - 8 words on the stream in order, one per cycle;
  - `done_o` one cycle after the 8th handshake.
- Base 0x0, stride 0xFFFFFFFC, count 3 → addresses 0x0, 0xFFFFFFFC, 0xFFFFFFF8 (wrap and negative stride).
- `ready_i=0` for 20 cycles, count 10:
  - exactly 4 grants, then `mem_req_o` stays low;
  - after `ready_i` rises, all 10 words arrive in order with no loss.
- Random `mem_gnt_i` stalls:
  - `mem_req_o` and `mem_addr_o` never change while not granted;
  - response data equals the address-tagged memory model.
- `count_i=0` → `done_o` at cycle 1, no `mem_req_o`. A `start_i` pulsed while busy is ignored.
- Reset asserted mid-RUN with 2 words queued: all outputs 0 immediately; a new start afterwards completes normally.
